sub_serial4: RTL and testbench

Bit-serial unsigned subtractor, the counterpart of the combinational ripple adders in the arithmetic library. It computes D = A − B one bit per clock, LSB first, through a single full-subtractor cell. It exposes a start/busy/done handshake so that a controller or testbench can reuse one small datapath where a full-width ripple chain is not wanted.

---
 rtl/sub_serial4_pkg.sv | 16 +
 rtl/sub_serial4_full_sub.sv | 13 +
 rtl/sub_serial4.sv | 113 +++++++++++
 tb/tb_sub_serial4.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_serial4_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and
// the bit-counter width helper.
package sub_serial_defs;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Counter must be able to hold WIDTH itself, hence the +1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sub_serial4_full_sub.sv
// Single-bit full subtractor cell (dual of the full-adder cell): D = A - B - Bin.
module full_sub (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);

    assign D    = A ^ B ^ Bin;
    assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/sub_serial4.sv
// Bit-serial unsigned subtractor D = A - B, LSB first, one full_sub per clock.
// Optional signed-overflow output OVF is compiled in with SUB_SERIAL_OVF_EN.
module sub_serial4
    import sub_serial_defs::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
`ifdef SUB_SERIAL_OVF_EN
    output logic             OVF,
`endif
    output state_t           state_dbg
);

    // Handshake: start is a request sampled only while busy = 0 (IDLE or the
    // DONE cycle); the accepting edge captures A/B. done is a one-cycle pulse
    // and D/Bout/OVF stay valid from then until the next completion.

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Holds the first WIDTH-1 difference bits; the last bit joins it on completion.
    logic [WIDTH-2:0] res_sh;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             cell_d;
    logic             cell_b;
`ifdef SUB_SERIAL_OVF_EN
    logic             ovf_q;
`endif

    full_sub u_cell (
        .A    (a_sh[0]),
        .B    (b_sh[0]),
        .Bin  (borrow),
        .D    (cell_d),
        .Bout (cell_b)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            D       <= '0;
            Bout    <= 1'b0;
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            borrow  <= 1'b0;
            cnt     <= '0;
`ifdef SUB_SERIAL_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh    <= A;
                        b_sh    <= B;
                        borrow  <= 1'b0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= (WIDTH-1)'({cell_d, res_sh} >> 1);
                    borrow <= cell_b;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        D       <= {cell_d, res_sh};
                        Bout    <= cell_b;
`ifdef SUB_SERIAL_OVF_EN
                        // On the last bit the cell sees the operand MSBs and produces D's MSB.
                        ovf_q   <= (a_sh[0] ^ b_sh[0]) & (a_sh[0] ^ cell_d);
`endif
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef SUB_SERIAL_OVF_EN
    assign OVF = ovf_q;
`endif

    assign state_dbg = state_q;

endmodule

// File: tb/tb_sub_serial4.sv
// Directed self-checking bench for sub_serial4 (WIDTH = 4); OVF checks are
// included when SUB_SERIAL_OVF_EN is defined.
module tb_sub_serial4;
    import sub_serial_defs::*;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         bo;
        logic         ovf;
    } vec_t;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] D;
    logic         Bout;
`ifdef SUB_SERIAL_OVF_EN
    logic         OVF;
`endif
    state_t       state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    sub_serial4 #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .D         (D),
        .Bout      (Bout),
`ifdef SUB_SERIAL_OVF_EN
        .OVF       (OVF),
`endif
        .state_dbg (state_dbg)
    );

    // clock / reset
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // driver: one start pulse, then wait (bounded) for done
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int busy_cycles, output bit timed_out);
        A = a;
        B = b;
        start = 1'b1;
        step();
        start = 1'b0;
        lat = 1;
        busy_cycles = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cycles++;
            step();
            lat++;
        end
        timed_out = !done;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++;
        if (D !== 4'd0) begin n_fail++; $display("FAIL reset_D: got %0d expected 0", D); end
        n_checks++;
        if (Bout !== 1'b0) begin n_fail++; $display("FAIL reset_Bout: got %b expected 0", Bout); end
        n_checks++;
        if (state_dbg !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, IDLE); end
`ifdef SUB_SERIAL_OVF_EN
        n_checks++;
        if (OVF !== 1'b0) begin n_fail++; $display("FAIL reset_OVF: got %b expected 0", OVF); end
`endif
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        vec_t vecs [7];
        int   lat;
        int   bc;
        bit   to;
        vecs[0] = '{a: 4'd9, b: 4'd5,  d: 4'd4,  bo: 1'b0, ovf: 1'b1};
        vecs[1] = '{a: 4'd5, b: 4'd9,  d: 4'd12, bo: 1'b1, ovf: 1'b1};
        vecs[2] = '{a: 4'd0, b: 4'd15, d: 4'd1,  bo: 1'b1, ovf: 1'b0};
        vecs[3] = '{a: 4'd0, b: 4'd0,  d: 4'd0,  bo: 1'b0, ovf: 1'b0};
        vecs[4] = '{a: 4'd8, b: 4'd1,  d: 4'd7,  bo: 1'b0, ovf: 1'b1};
        vecs[5] = '{a: 4'd7, b: 4'd15, d: 4'd8,  bo: 1'b1, ovf: 1'b1};
        vecs[6] = '{a: 4'd6, b: 4'd2,  d: 4'd4,  bo: 1'b0, ovf: 1'b0};
        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].a, vecs[i].b, lat, bc, to);
            n_checks++;
            if (to) begin n_fail++; $display("FAIL basic_timeout[%0d]: no done within %0d cycles", i, lat); end
            n_checks++;
            if (lat !== W + 1) begin n_fail++; $display("FAIL basic_latency[%0d]: got %0d expected %0d", i, lat, W + 1); end
            n_checks++;
            if (bc !== W) begin n_fail++; $display("FAIL basic_busy_cycles[%0d]: got %0d expected %0d", i, bc, W); end
            n_checks++;
            if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_in_done[%0d]: got %b expected 0", i, busy); end
            n_checks++;
            if (D !== vecs[i].d) begin n_fail++; $display("FAIL basic_D[%0d]: got %0d expected %0d", i, D, vecs[i].d); end
            n_checks++;
            if (Bout !== vecs[i].bo) begin n_fail++; $display("FAIL basic_Bout[%0d]: got %b expected %b", i, Bout, vecs[i].bo); end
`ifdef SUB_SERIAL_OVF_EN
            n_checks++;
            if (OVF !== vecs[i].ovf) begin n_fail++; $display("FAIL basic_OVF[%0d]: got %b expected %b", i, OVF, vecs[i].ovf); end
`endif
            step();
            n_checks++;
            if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse[%0d]: got %b expected 0", i, done); end
            n_checks++;
            if (D !== vecs[i].d) begin n_fail++; $display("FAIL basic_D_hold[%0d]: got %0d expected %0d", i, D, vecs[i].d); end
        end
    endtask

    task automatic test_ignore_start();
        int          n_done = 0;
        logic [W-1:0] first_d = '0;
        logic         first_bo = 1'b0;
        A = 4'd3;
        B = 4'd1;
        start = 1'b1;
        step();              // T0
        start = 1'b0;
        step();              // T1
        A = 4'd15;
        B = 4'd0;
        start = 1'b1;
        step();              // T2: start while busy
        start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (done) begin
                if (n_done == 0) begin first_d = D; first_bo = Bout; end
                n_done++;
            end
            step();
        end
        n_checks++;
        if (n_done !== 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d expected 1", n_done); end
        n_checks++;
        if (first_d !== 4'd2) begin n_fail++; $display("FAIL ignore_D: got %0d expected 2", first_d); end
        n_checks++;
        if (first_bo !== 1'b0) begin n_fail++; $display("FAIL ignore_Bout: got %b expected 0", first_bo); end
        n_checks++;
        if (state_dbg !== IDLE) begin n_fail++; $display("FAIL ignore_state: got %0d expected %0d", state_dbg, IDLE); end
    endtask

    task automatic test_reset_abort();
        int n_done = 0;
        int lat;
        int bc;
        bit to;
        A = 4'd12;
        B = 4'd3;
        start = 1'b1;
        step();              // T0
        start = 1'b0;
        step();              // T1
        step();              // T2
        reset = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b expected 0", done); end
        n_checks++;
        if (D !== 4'd0) begin n_fail++; $display("FAIL abort_D: got %0d expected 0", D); end
        n_checks++;
        if (Bout !== 1'b0) begin n_fail++; $display("FAIL abort_Bout: got %b expected 0", Bout); end
        n_checks++;
        if (state_dbg !== IDLE) begin n_fail++; $display("FAIL abort_state: got %0d expected %0d", state_dbg, IDLE); end
`ifdef SUB_SERIAL_OVF_EN
        n_checks++;
        if (OVF !== 1'b0) begin n_fail++; $display("FAIL abort_OVF: got %b expected 0", OVF); end
`endif
        step();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done) n_done++;
            step();
        end
        n_checks++;
        if (n_done !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses expected 0", n_done); end
        do_op(4'd12, 4'd3, lat, bc, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL abort_retry_timeout: no done within %0d cycles", lat); end
        n_checks++;
        if (D !== 4'd9) begin n_fail++; $display("FAIL abort_retry_D: got %0d expected 9", D); end
        n_checks++;
        if (Bout !== 1'b0) begin n_fail++; $display("FAIL abort_retry_Bout: got %b expected 0", Bout); end
        step();
    endtask

    task automatic test_back_to_back();
        int          idx [2] = '{-1, -1};
        logic [W-1:0] dv [2] = '{4'd0, 4'd0};
        int          n_done = 0;
        A = 4'd7;
        B = 4'd2;
        start = 1'b1;
        step();              // T0
        A = 4'd6;
        B = 4'd6;
        for (int i = 1; i <= 9; i++) begin
            step();
            if (done) begin
                if (n_done < 2) begin idx[n_done] = i; dv[n_done] = D; end
                n_done++;
            end
        end
        start = 1'b0;
        step();
        n_checks++;
        if (n_done !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 2", n_done); end
        n_checks++;
        if (idx[0] !== W) begin n_fail++; $display("FAIL b2b_first_edge: got %0d expected %0d", idx[0], W); end
        n_checks++;
        if (dv[0] !== 4'd5) begin n_fail++; $display("FAIL b2b_first_D: got %0d expected 5", dv[0]); end
        n_checks++;
        if (idx[1] !== 2 * W + 1) begin n_fail++; $display("FAIL b2b_second_edge: got %0d expected %0d", idx[1], 2 * W + 1); end
        n_checks++;
        if (dv[1] !== 4'd0) begin n_fail++; $display("FAIL b2b_second_D: got %0d expected 0", dv[1]); end
        n_checks++;
        if (state_dbg !== IDLE) begin n_fail++; $display("FAIL b2b_state_after: got %0d expected %0d", state_dbg, IDLE); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
